// File: rtl/cdc_2phase_mux_dst.sv
// Receiving half of a multi-channel two-phase (toggle) CDC. Each link's request is synchronised,
// its word is held per channel, and all channels are merged onto one tagged valid/ready stream.
module cdc_2phase_mux_dst #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FAIR        = 1,
  localparam int unsigned IdxW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            async_req_i,
  output logic [NUM_CH-1:0]            async_ack_o,
  input  logic [NUM_CH*DATA_WIDTH-1:0] async_data_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic [IdxW-1:0]              idx_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [NUM_CH-1:0]            pending_o
);

  (* async_reg = "true" *) logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
  logic [DATA_WIDTH-1:0]  data_q [NUM_CH];
  logic [DATA_WIDTH-1:0]  data_d [NUM_CH];
  logic [NUM_CH-1:0]      ack_q, ack_d;
  logic [NUM_CH-1:0]      full_q, full_d;
  logic                   lock_q, lock_d;
  logic [IdxW-1:0]        lock_idx_q, lock_idx_d;
  logic [IdxW-1:0]        rr_q, rr_d;

  logic [NUM_CH-1:0]      rr_mask, masked_req, search_req;
  logic [IdxW-1:0]        arb_gnt, grant;
  logic                   release_en;

  // Arbitration: round-robin searches upward from rr_q first, then wraps to the lowest index.
  always_comb begin
    rr_mask    = (FAIR != 0) ? ({NUM_CH{1'b1}} << rr_q) : '0;
    masked_req = full_q & rr_mask;
    search_req = (masked_req != '0) ? masked_req : full_q;
    arb_gnt    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (search_req[i]) begin
        arb_gnt = IdxW'(i);
      end
    end
    // A presented word keeps its grant until accepted.
    grant = lock_q ? lock_idx_q : arb_gnt;
  end

  always_comb begin
    valid_o     = |full_q;
    idx_o       = grant;
    pending_o   = full_q;
    async_ack_o = ack_q;
    data_o      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == IdxW'(i)) begin
        data_o = data_q[i];
      end
    end
  end

  always_comb begin
    release_en = valid_o & ready_i;
    for (int i = 0; i < NUM_CH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], async_req_i[i]};
      ack_d[i]  = ack_q[i];
      full_d[i] = full_q[i];
      data_d[i] = data_q[i];
      if (release_en && (grant == IdxW'(i))) begin
        full_d[i] = 1'b0;
        ack_d[i]  = ~ack_q[i];
      end else if (!full_q[i] && (sync_q[i][SYNC_STAGES-1] != ack_q[i])) begin
        full_d[i] = 1'b1;
        data_d[i] = async_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    if (valid_o && !ready_i) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end else if (release_en) begin
      lock_d = 1'b0;
      if (FAIR != 0) begin
        rr_d = (grant == IdxW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= '0;
        data_q[i] <= '0;
      end
      ack_q      <= '0;
      full_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rr_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= sync_d[i];
        data_q[i] <= data_d[i];
      end
      ack_q      <= ack_d;
      full_q     <= full_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
    end
  end

endmodule
